// File: rtl/uart_top.sv
// Full-duplex 8N1 UART with a fixed integer baud divider; TX and RX halves are independent.
// Optional macro UART_FRAME_ERR_EN adds the rx_frame_err status output.
`timescale 1ns/1ps
module uart_top #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid
`ifdef UART_FRAME_ERR_EN
    ,
    output logic       rx_frame_err
`endif
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           tx_state_r, tx_state_nxt_s;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_nxt_s;
    logic [2:0]       tx_bit_r, tx_bit_nxt_s;
    logic [7:0]       tx_shift_r, tx_shift_nxt_s;
    logic             tx_r, tx_nxt_s, tx_busy_r, tx_busy_nxt_s, tx_done_r, tx_done_nxt_s;
    logic             tx_tick_s;

    state_t           rx_state_r, rx_state_nxt_s;
    logic [CNT_W-1:0] rx_cnt_r, rx_cnt_nxt_s;
    logic [2:0]       rx_bit_r, rx_bit_nxt_s;
    logic [7:0]       rx_shift_r, rx_shift_nxt_s, rx_data_r, rx_data_nxt_s;
    logic             rx_valid_r, rx_valid_nxt_s;
    logic             rx_meta_r, rx_sync_r, rx_prev_r;
    logic             rx_edge_s, rx_half_tick_s, rx_full_tick_s;
`ifdef UART_FRAME_ERR_EN
    logic             rx_ferr_r, rx_ferr_nxt_s;
`endif

    assign tx_tick_s      = (tx_cnt_r == BIT_LAST);
    assign rx_half_tick_s = (rx_cnt_r == HALF_LAST);
    assign rx_full_tick_s = (rx_cnt_r == BIT_LAST);
    assign rx_edge_s      = rx_prev_r & ~rx_sync_r;

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_r <= ST_IDLE;
        else        tx_state_r <= tx_state_nxt_s;
    end

    // TX next-state logic
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            ST_IDLE:  if (tx_start) tx_state_nxt_s = ST_START; else tx_state_nxt_s = ST_IDLE;
            ST_START: if (tx_tick_s) tx_state_nxt_s = ST_DATA; else tx_state_nxt_s = ST_START;
            ST_DATA:  if (tx_tick_s && (tx_bit_r == 3'd7)) tx_state_nxt_s = ST_STOP;
                      else tx_state_nxt_s = ST_DATA;
            ST_STOP:  if (tx_tick_s) tx_state_nxt_s = ST_IDLE; else tx_state_nxt_s = ST_STOP;
            default:  tx_state_nxt_s = ST_IDLE;
        endcase
    end

    // TX output/datapath next values; line level follows the state being entered so it is registered
    always_comb begin
        tx_cnt_nxt_s   = tx_cnt_r + CNT_W'(1);
        tx_bit_nxt_s   = tx_bit_r;
        tx_shift_nxt_s = tx_shift_r;
        if (tx_state_r == ST_IDLE || tx_tick_s) tx_cnt_nxt_s = {CNT_W{1'b0}};
        else                                     tx_cnt_nxt_s = tx_cnt_r + CNT_W'(1);
        case (tx_state_r)
            ST_IDLE: begin
                tx_bit_nxt_s = 3'd0;
                if (tx_start) tx_shift_nxt_s = tx_data;
                else          tx_shift_nxt_s = tx_shift_r;
            end
            ST_DATA: begin
                if (tx_tick_s) begin
                    tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
                    tx_bit_nxt_s   = tx_bit_r + 3'd1;
                end else begin
                    tx_shift_nxt_s = tx_shift_r;
                    tx_bit_nxt_s   = tx_bit_r;
                end
            end
            default: tx_bit_nxt_s = tx_bit_r;
        endcase
        case (tx_state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = tx_shift_nxt_s[0];
            default:  tx_nxt_s = 1'b1;
        endcase
        tx_busy_nxt_s = (tx_state_nxt_s != ST_IDLE);
        tx_done_nxt_s = (tx_state_r == ST_STOP) && (tx_state_nxt_s == ST_IDLE);
    end

    // TX datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_r   <= {CNT_W{1'b0}};
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_cnt_r   <= tx_cnt_nxt_s;
            tx_bit_r   <= tx_bit_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            tx_r       <= tx_nxt_s;
            tx_busy_r  <= tx_busy_nxt_s;
            tx_done_r  <= tx_done_nxt_s;
        end
    end

    // RX two-flop synchronizer plus previous-value flop for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_r <= ST_IDLE;
        else        rx_state_r <= rx_state_nxt_s;
    end

    // RX next-state logic; a line still low after a bad stop bit cannot produce a new edge
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        case (rx_state_r)
            ST_IDLE:  if (rx_edge_s) rx_state_nxt_s = ST_START; else rx_state_nxt_s = ST_IDLE;
            ST_START: if (rx_half_tick_s) rx_state_nxt_s = rx_sync_r ? ST_IDLE : ST_DATA;
                      else rx_state_nxt_s = ST_START;
            ST_DATA:  if (rx_full_tick_s && (rx_bit_r == 3'd7)) rx_state_nxt_s = ST_STOP;
                      else rx_state_nxt_s = ST_DATA;
            ST_STOP:  if (rx_full_tick_s) rx_state_nxt_s = ST_IDLE; else rx_state_nxt_s = ST_STOP;
            default:  rx_state_nxt_s = ST_IDLE;
        endcase
    end

    // RX output/datapath next values
    always_comb begin
        rx_bit_nxt_s   = rx_bit_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_data_nxt_s  = rx_data_r;
        rx_valid_nxt_s = rx_valid_r;
`ifdef UART_FRAME_ERR_EN
        rx_ferr_nxt_s  = rx_ferr_r;
`endif
        if (rx_state_r == ST_IDLE || rx_state_nxt_s != rx_state_r || rx_full_tick_s)
            rx_cnt_nxt_s = {CNT_W{1'b0}};
        else
            rx_cnt_nxt_s = rx_cnt_r + CNT_W'(1);
        case (rx_state_r)
            ST_IDLE: begin
                rx_bit_nxt_s = 3'd0;
                if (rx_edge_s) rx_valid_nxt_s = 1'b0;
                else           rx_valid_nxt_s = rx_valid_r;
            end
            ST_START: begin
`ifdef UART_FRAME_ERR_EN
                if (rx_half_tick_s && !rx_sync_r) rx_ferr_nxt_s = 1'b0;
                else                              rx_ferr_nxt_s = rx_ferr_r;
`endif
                rx_bit_nxt_s = 3'd0;
            end
            ST_DATA: begin
                if (rx_full_tick_s) begin
                    rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_nxt_s   = rx_bit_r + 3'd1;
                end else begin
                    rx_shift_nxt_s = rx_shift_r;
                    rx_bit_nxt_s   = rx_bit_r;
                end
            end
            ST_STOP: begin
                if (rx_full_tick_s && rx_sync_r) begin
                    rx_data_nxt_s  = rx_shift_r;
                    rx_valid_nxt_s = 1'b1;
                end else begin
`ifdef UART_FRAME_ERR_EN
                    if (rx_full_tick_s) rx_ferr_nxt_s = 1'b1;
                    else                rx_ferr_nxt_s = rx_ferr_r;
`endif
                    rx_data_nxt_s  = rx_data_r;
                    rx_valid_nxt_s = rx_valid_r;
                end
            end
            default: rx_bit_nxt_s = 3'd0;
        endcase
    end

    // RX datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_r   <= {CNT_W{1'b0}};
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            rx_ferr_r  <= 1'b0;
`endif
        end else begin
            rx_cnt_r   <= rx_cnt_nxt_s;
            rx_bit_r   <= rx_bit_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_valid_r <= rx_valid_nxt_s;
`ifdef UART_FRAME_ERR_EN
            rx_ferr_r  <= rx_ferr_nxt_s;
`endif
        end
    end

    assign tx       = tx_r;
    assign tx_busy  = tx_busy_r;
    assign tx_done  = tx_done_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
`ifdef UART_FRAME_ERR_EN
    assign rx_frame_err = rx_ferr_r;
`endif

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: loopback frames, ignored tx_start, reset mid-frame,
// framing error, false start and a bench-driven receive sequence.
`timescale 1ns/1ps
module tb_uart_top;

    localparam int CPB = 868;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, tx;
    logic       rx;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef UART_FRAME_ERR_EN
    logic       rx_frame_err;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    int         obs_done_cyc, obs_extra_done;
    logic       obs_busy0, obs_tx0, obs_valid_mid, obs_valid_done, obs_busy_after;
    logic [7:0] obs_data;

    assign rx = loop_en ? tx : rx_drv;

    uart_top dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx       (tx),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef UART_FRAME_ERR_EN
        ,
        .rx_frame_err (rx_frame_err)
`endif
    );

    always #5 clk = ~clk;

    // Launch one TX frame and record what is observed; optionally re-request mid-frame with 0x00.
    task automatic tx_frame(input logic [7:0] b, input bit poke);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        obs_busy0 = tx_busy;
        obs_tx0   = tx;
        obs_done_cyc   = -1;
        obs_valid_mid  = 1'bx;
        obs_extra_done = 0;
        for (int c = 1; c <= 200000; c++) begin
            @(negedge clk);
            if (c == 100) begin
                obs_valid_mid = rx_valid;
                if (poke) begin
                    tx_start = 1'b1;
                    tx_data  = 8'h00;
                end
            end
            if (c == 101) tx_start = 1'b0;
            if (tx_done) begin
                obs_done_cyc = c;
                break;
            end
        end
        tx_start       = 1'b0;
        obs_data       = rx_data;
        obs_valid_done = rx_valid;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_done) obs_extra_done++;
        end
        obs_busy_after = tx_busy;
    endtask

    // Drive 8 data bits LSB first on the rx line.
    task automatic rx_bits(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++; if (tx !== 1'b1) begin err_cnt++; $display("FAIL reset_tx: got %b want 1", tx); end
        vec_cnt++; if (tx_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        vec_cnt++; if (tx_done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", tx_done); end
        vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
`ifdef UART_FRAME_ERR_EN
        vec_cnt++; if (rx_frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vec_cnt++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            err_cnt++; $display("FAIL post_reset_idle: tx=%b busy=%b want tx=1 busy=0", tx, tx_busy);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
        loop_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_frame(bytes[i], (i == 1));
            vec_cnt++; if (obs_busy0 !== 1'b1 || obs_tx0 !== 1'b0) begin
                err_cnt++; $display("FAIL lb_start[%0d]: busy=%b tx=%b want busy=1 tx=0", i, obs_busy0, obs_tx0);
            end
            vec_cnt++; if (obs_done_cyc != 8680) begin
                err_cnt++; $display("FAIL lb_done_latency[%0d]: got %0d want 8680", i, obs_done_cyc);
            end
            vec_cnt++; if (obs_valid_mid !== 1'b0) begin
                err_cnt++; $display("FAIL lb_valid_cleared[%0d]: got %b want 0", i, obs_valid_mid);
            end
            vec_cnt++; if (obs_valid_done !== 1'b1 || obs_data !== bytes[i]) begin
                err_cnt++; $display("FAIL lb_rx[%0d]: valid=%b data=%h want valid=1 data=%h", i, obs_valid_done, obs_data, bytes[i]);
            end
            vec_cnt++; if (obs_extra_done != 0 || obs_busy_after !== 1'b0) begin
                err_cnt++; $display("FAIL lb_single_done[%0d]: extra=%0d busy=%b want extra=0 busy=0", i, obs_extra_done, obs_busy_after);
            end
            vec_cnt++; if (rx_valid !== 1'b1) begin
                err_cnt++; $display("FAIL lb_valid_held[%0d]: got %b want 1", i, rx_valid);
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        loop_en = 1'b1;
        @(negedge clk);
        tx_data  = 8'hF0;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * CPB + 400) @(negedge clk);
        vec_cnt++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            err_cnt++; $display("FAIL rst_mid_pre: tx=%b busy=%b want tx=0 busy=1", tx, tx_busy);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (tx !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_tx_async: got %b want 1", tx); end
        vec_cnt++; if (tx_busy !== 1'b0 || tx_done !== 1'b0 || rx_valid !== 1'b0) begin
            err_cnt++; $display("FAIL rst_mid_flags: busy=%b done=%b valid=%b want 0 0 0", tx_busy, tx_done, rx_valid);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tx_frame(8'h3F, 1'b0);
        vec_cnt++; if (obs_done_cyc != 8680) begin
            err_cnt++; $display("FAIL rst_mid_latency: got %0d want 8680", obs_done_cyc);
        end
        vec_cnt++; if (obs_valid_done !== 1'b1 || obs_data !== 8'h3F) begin
            err_cnt++; $display("FAIL rst_mid_rx: valid=%b data=%h want valid=1 data=3f", obs_valid_done, obs_data);
        end
    endtask

    task automatic test_frame_err();
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (20) @(negedge clk);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_bits(8'h55);
        rx_drv = 1'b0;
        repeat (500) @(negedge clk);
        vec_cnt++; if (rx_valid !== 1'b0 || rx_data !== 8'h3F) begin
            err_cnt++; $display("FAIL ferr_discard: valid=%b data=%h want valid=0 data=3f", rx_valid, rx_data);
        end
`ifdef UART_FRAME_ERR_EN
        vec_cnt++; if (rx_frame_err !== 1'b1) begin err_cnt++; $display("FAIL ferr_flag: got %b want 1", rx_frame_err); end
`endif
        repeat (CPB - 500) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
    endtask

    task automatic test_false_start();
        loop_en = 1'b0;
        rx_drv  = 1'b0;
        repeat (200) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
        vec_cnt++; if (rx_valid !== 1'b0 || rx_data !== 8'h3F) begin
            err_cnt++; $display("FAIL false_start: valid=%b data=%h want valid=0 data=3f", rx_valid, rx_data);
        end
`ifdef UART_FRAME_ERR_EN
        vec_cnt++; if (rx_frame_err !== 1'b1) begin err_cnt++; $display("FAIL false_start_ferr: got %b want 1", rx_frame_err); end
`endif
    endtask

    task automatic test_rx_sequence();
        logic [7:0] bytes [4];
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h04; bytes[3] = 8'h3F;
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_drv = 1'b0;
            repeat (20) @(negedge clk);
            vec_cnt++; if (rx_valid !== 1'b0) begin
                err_cnt++; $display("FAIL seq_valid_fall[%0d]: got %b want 0", i, rx_valid);
            end
            repeat (CPB - 20) @(negedge clk);
            rx_bits(bytes[i]);
            rx_drv = 1'b1;
            repeat (400) @(negedge clk);
            vec_cnt++; if (rx_valid !== 1'b0) begin
                err_cnt++; $display("FAIL seq_valid_early[%0d]: got %b want 0", i, rx_valid);
            end
            repeat (100) @(negedge clk);
            vec_cnt++; if (rx_valid !== 1'b1 || rx_data !== bytes[i]) begin
                err_cnt++; $display("FAIL seq_rx[%0d]: valid=%b data=%h want valid=1 data=%h", i, rx_valid, rx_data, bytes[i]);
            end
`ifdef UART_FRAME_ERR_EN
            vec_cnt++; if (rx_frame_err !== 1'b0) begin err_cnt++; $display("FAIL seq_ferr[%0d]: got %b want 0", i, rx_frame_err); end
`endif
            repeat (CPB - 500) @(negedge clk);
            repeat (1000) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_reset_mid_tx();
        test_frame_err();
        test_false_start();
        test_rx_sequence();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
